param_shift_unit: RTL and testbench

//  Parametrised multi-mode shift/rotate register, successor to the 4-bit load/rotate/ASR register.

---
 rtl/param_shift_unit.sv | 169 ++++++++++++++++
 tb/tb_param_shift_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_shift_unit.sv
// -----------------------------------------------------------------------------
// param_shift_unit
//   Parametrised multi-mode shift/rotate register. A command is accepted with
//   start while the unit is idle. LOAD writes data_in in a single cycle. Every
//   other op executes 'amount' one-bit steps, one step per clock, and then
//   raises done for one cycle. An amount of zero completes at once and leaves
//   Q unchanged.
//
// Parameters
//   WIDTH       data width in bits (>= 2)
//   AMT_W       width of the shift-amount port
//
// Ports
//   clock       in   1      rising-edge clock
//   reset       in   1      synchronous, active-high; overrides everything
//   start       in   1      command request, honoured only while busy is low
//   op          in   3      000 LOAD,001 SLL,010 SRL,011 SRA,100 ROL,101 ROR,
//                           110 SLS,111 SRS
//   amount      in   AMT_W  number of one-bit steps (ignored for LOAD)
//   data_in     in   WIDTH  parallel load value
//   serial_in   in   1      fill bit for SLS/SRS, sampled at every step
//   Q           out  WIDTH  register contents
//   serial_out  out  1      last bit shifted or rotated out (registered)
//   busy        out  1      high while a multi-step op is running
//   done        out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module param_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_SLS  = 3'b110;
    localparam logic [2:0] OP_SRS  = 3'b111;

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [2:0]         op_q;
    logic [AMT_W-1:0]   count_q;
    logic [WIDTH-1:0]   data_q;
    logic               so_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   step_d;
    logic               step_so_d;

    // Result of one single-bit step of the latched op applied to the current contents.
    always_comb begin
        step_d    = data_q;
        step_so_d = so_q;
        case (op_q)
            OP_SLL: begin
                step_d    = {data_q[WIDTH-2:0], 1'b0};
                step_so_d = data_q[WIDTH-1];
            end
            OP_SRL: begin
                step_d    = {1'b0, data_q[WIDTH-1:1]};
                step_so_d = data_q[0];
            end
            OP_SRA: begin
                step_d    = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_so_d = data_q[0];
            end
            OP_ROL: begin
                step_d    = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_so_d = data_q[WIDTH-1];
            end
            OP_ROR: begin
                step_d    = {data_q[0], data_q[WIDTH-1:1]};
                step_so_d = data_q[0];
            end
            OP_SLS: begin
                step_d    = {data_q[WIDTH-2:0], serial_in};
                step_so_d = data_q[WIDTH-1];
            end
            OP_SRS: begin
                step_d    = {serial_in, data_q[WIDTH-1:1]};
                step_so_d = data_q[0];
            end
            default: begin
                // LOAD never reaches RUN; hold contents.
                step_d    = data_q;
                step_so_d = so_q;
            end
        endcase
    end

    // Control FSM together with the data register and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            count_q <= CNT_ZERO;
            data_q  <= {WIDTH{1'b0}};
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // done is a pulse: cleared unless this edge completes a command.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_LOAD) begin
                            data_q <= data_in;
                            so_q   <= 1'b0;
                            done_q <= 1'b1;
                        end else if (amount == CNT_ZERO) begin
                            done_q <= 1'b1;
                        end else begin
                            // Accept only: the first step happens on the next edge.
                            op_q    <= op;
                            count_q <= amount;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // start/op/amount/data_in are deliberately not looked at here.
                    data_q  <= step_d;
                    so_q    <= step_so_d;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    count_q <= CNT_ZERO;
                end
            endcase
        end
    end

    assign Q          = data_q;
    assign serial_out = so_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_param_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_param_shift_unit
//   Self-checking bench for param_shift_unit (WIDTH=8, AMT_W=4). Expected
//   results come from a whole-command reference model that treats each op as
//   one arithmetic operation on an extended bit string (shift by N, rotate by
//   N mod WIDTH) rather than stepping bit by bit.
// -----------------------------------------------------------------------------
module tb_param_shift_unit;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_SLS  = 3'b110;
    localparam logic [2:0] OP_SRS  = 3'b111;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [3:0] amount;
    logic [7:0] data_in;
    logic       serial_in;
    logic [7:0] Q;
    logic       serial_out;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_err;

    // Reference state: register contents and serial_out after each command.
    logic [7:0] m_q;
    logic       m_so;

    param_shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .amount     (amount),
        .data_in    (data_in),
        .serial_in  (serial_in),
        .Q          (Q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Whole-command model: returns {Q, serial_out} after n steps.
    // sb[k] is the serial_in value present at step k+1.
    function automatic logic [8:0] model(input logic [2:0] c_op, input int n,
                                         input logic [7:0] q, input logic so,
                                         input logic [15:0] sb);
        logic [63:0] l;
        logic [63:0] fill;
        logic [15:0] rr;
        logic [7:0]  res;
        logic        o;
        int          r;
        res = q;
        o   = so;
        if (n != 0) begin
            case (c_op)
                OP_SLL, OP_SLS: begin
                    // {q, s1..sN}: first sampled bit lands highest.
                    fill = 64'd0;
                    if (c_op == OP_SLS)
                        for (int k = 0; k < n; k++) fill = (fill << 1) | 64'(sb[k]);
                    l   = (64'(q) << n) | fill;
                    res = l[7:0];
                    o   = l[8];
                end
                OP_SRL, OP_SRA, OP_SRS: begin
                    // {sN..s1, q}: first sampled bit sits next to q.
                    fill = 64'd0;
                    if (c_op == OP_SRA && q[7]) fill = (64'd1 << n) - 64'd1;
                    if (c_op == OP_SRS) fill = 64'(sb) & ((64'd1 << n) - 64'd1);
                    l   = (fill << 8) | 64'(q);
                    l   = l >> n;
                    res = l[7:0];
                    l   = (fill << 8) | 64'(q);
                    o   = l[n-1];
                end
                OP_ROL: begin
                    r   = n % 8;
                    rr  = (16'(q) << r) | (16'(q) >> (8 - r));
                    res = rr[7:0];
                    o   = res[0];
                end
                OP_ROR: begin
                    r   = n % 8;
                    rr  = (16'(q) >> r) | (16'(q) << (8 - r));
                    res = rr[7:0];
                    o   = res[7];
                end
                default: begin
                    res = q;
                    o   = so;
                end
            endcase
        end
        return {res, o};
    endfunction

    // Issue one command, step it to completion and compare the final state.
    // noisy: keep wiggling start/op/amount/data_in while running.
    // idle_chk: check one extra idle cycle; otherwise return in the done cycle.
    task automatic do_cmd(input logic [2:0] c_op, input logic [3:0] c_amt,
                          input logic [7:0] c_din, input logic [15:0] c_sb,
                          input bit noisy, input bit idle_chk, input string tag);
        logic [8:0] exp;
        int         n;
        n = int'(c_amt);
        if (c_op == OP_LOAD) exp = {c_din, 1'b0};
        else                 exp = model(c_op, n, m_q, m_so, c_sb);
        start     = 1'b1;
        op        = c_op;
        amount    = c_amt;
        data_in   = c_din;
        serial_in = c_sb[0];
        @(posedge clock); #1;
        start = 1'b0;
        if (c_op != OP_LOAD && n != 0) begin
            for (int k = 0; k < n; k++) begin
                n_cmp++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s run_busy step %0d: busy=%b done=%b, want busy=1 done=0", tag, k, busy, done);
                end
                serial_in = c_sb[k];
                if (noisy) begin
                    start   = 1'($urandom);
                    op      = 3'($urandom);
                    amount  = 4'($urandom);
                    data_in = 8'($urandom);
                end
                @(posedge clock); #1;
            end
            start = 1'b0;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: done=%b busy=%b, want done=1 busy=0", tag, done, busy);
        end
        n_cmp++;
        if (Q !== exp[8:1] || serial_out !== exp[0]) begin
            n_err++;
            $display("FAIL %s result op=%0d amt=%0d: Q=%h so=%b, want Q=%h so=%b", tag, c_op, c_amt, Q, serial_out, exp[8:1], exp[0]);
        end
        m_q  = exp[8:1];
        m_so = exp[0];
        if (idle_chk) begin
            @(posedge clock); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || Q !== m_q || serial_out !== m_so) begin
                n_err++;
                $display("FAIL %s idle_hold: done=%b busy=%b Q=%h so=%b, want 0 0 %h %b", tag, done, busy, Q, serial_out, m_q, m_so);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = OP_LOAD; amount = 4'd0;
        data_in = 8'd0; serial_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (Q !== 8'h00 || serial_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: Q=%h so=%b busy=%b done=%b, want 00 0 0 0", Q, serial_out, busy, done);
        end
        m_q  = 8'h00;
        m_so = 1'b0;
    endtask

    task automatic test_load_ror();
        logic [7:0] inter [3];
        inter[0] = 8'hD2; inter[1] = 8'h69; inter[2] = 8'hB4;
        do_cmd(OP_LOAD, 4'd0, 8'hA5, 16'h0000, 1'b0, 1'b1, "load_a5");
        start = 1'b1; op = OP_ROR; amount = 4'd3;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL ror3_busy cycle %0d: busy=%b, want 1", k, busy);
            end
            @(posedge clock); #1;
            n_cmp++;
            if (Q !== inter[k]) begin
                n_err++;
                $display("FAIL ror3_step %0d: Q=%h, want %h", k, Q, inter[k]);
            end
        end
        n_cmp++;
        if (serial_out !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ror3_final: so=%b done=%b busy=%b, want 1 1 0", serial_out, done, busy);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL ror3_done_width: done=%b, want 0", done);
        end
        m_q  = 8'hB4;
        m_so = 1'b1;
    endtask

    task automatic test_sra_srl();
        do_cmd(OP_LOAD, 4'd0, 8'h90, 16'h0000, 1'b0, 1'b0, "load_90a");
        do_cmd(OP_SRA, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b1, "sra2");
        n_cmp++;
        if (Q !== 8'hE4) begin
            n_err++;
            $display("FAIL sra2_const: Q=%h, want e4", Q);
        end
        do_cmd(OP_LOAD, 4'd0, 8'h90, 16'h0000, 1'b0, 1'b0, "load_90b");
        do_cmd(OP_SRL, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b1, "srl2");
        n_cmp++;
        if (Q !== 8'h24 || serial_out !== 1'b0) begin
            n_err++;
            $display("FAIL srl2_const: Q=%h so=%b, want 24 0", Q, serial_out);
        end
    endtask

    task automatic test_large_amount();
        do_cmd(OP_LOAD, 4'd0, 8'h81, 16'h0000, 1'b0, 1'b0, "load_81a");
        do_cmd(OP_SLL, 4'd9, 8'h00, 16'h0000, 1'b0, 1'b1, "sll9");
        do_cmd(OP_LOAD, 4'd0, 8'h81, 16'h0000, 1'b0, 1'b0, "load_81b");
        do_cmd(OP_ROL, 4'd8, 8'h00, 16'h0000, 1'b0, 1'b1, "rol8");
        n_cmp++;
        if (Q !== 8'h81 || serial_out !== 1'b1) begin
            n_err++;
            $display("FAIL rol8_const: Q=%h so=%b, want 81 1", Q, serial_out);
        end
        do_cmd(OP_LOAD, 4'd0, 8'hC3, 16'h0000, 1'b0, 1'b0, "load_c3");
        do_cmd(OP_SRA, 4'd15, 8'h00, 16'h0000, 1'b0, 1'b1, "sra15");
    endtask

    task automatic test_serial();
        do_cmd(OP_LOAD, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b0, "load_00");
        do_cmd(OP_SLS, 4'd4, 8'h00, 16'hFFFF, 1'b0, 1'b1, "sls4");
        n_cmp++;
        if (Q !== 8'h0F) begin
            n_err++;
            $display("FAIL sls4_const: Q=%h, want 0f", Q);
        end
        do_cmd(OP_SRS, 4'd1, 8'h00, 16'h0000, 1'b0, 1'b1, "srs1");
        n_cmp++;
        if (Q !== 8'h07 || serial_out !== 1'b1) begin
            n_err++;
            $display("FAIL srs1_const: Q=%h so=%b, want 07 1", Q, serial_out);
        end
        // serial_in varying per step exercises per-step sampling.
        do_cmd(OP_SLS, 4'd6, 8'h00, 16'b0000_0000_0010_1101, 1'b0, 1'b1, "sls6_mix");
        do_cmd(OP_SRS, 4'd5, 8'h00, 16'b0000_0000_0001_0110, 1'b0, 1'b1, "srs5_mix");
    endtask

    task automatic test_zero_and_busy();
        do_cmd(OP_LOAD, 4'd0, 8'h5A, 16'h0000, 1'b0, 1'b0, "load_5a");
        do_cmd(OP_SLL, 4'd0, 8'hFF, 16'h0000, 1'b0, 1'b1, "sll0");
        do_cmd(OP_ROR, 4'd0, 8'hFF, 16'h0000, 1'b0, 1'b1, "ror0");
        do_cmd(OP_ROL, 4'd5, 8'h00, 16'h0000, 1'b1, 1'b1, "rol5_noisy");
    endtask

    task automatic test_back_to_back();
        do_cmd(OP_LOAD, 4'd0, 8'h3C, 16'h0000, 1'b0, 1'b0, "b2b_load");
        do_cmd(OP_SRL, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b0, "b2b_srl");
        do_cmd(OP_ROR, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b0, "b2b_ror");
        do_cmd(OP_SLS, 4'd3, 8'h00, 16'h0005, 1'b0, 1'b1, "b2b_sls");
    endtask

    task automatic test_reset_mid_run();
        do_cmd(OP_LOAD, 4'd0, 8'hF7, 16'h0000, 1'b0, 1'b0, "rst_load");
        start = 1'b1; op = OP_SRL; amount = 4'd5;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_cmp++;
        if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || serial_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_run: Q=%h busy=%b done=%b so=%b, want 00 0 0 0", Q, busy, done, serial_out);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || Q !== 8'h00) begin
                n_err++;
                $display("FAIL reset_no_done cycle %0d: done=%b busy=%b Q=%h, want 0 0 00", k, done, busy, Q);
            end
        end
        m_q  = 8'h00;
        m_so = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  r_op;
        logic [3:0]  r_amt;
        logic [7:0]  r_din;
        logic [15:0] r_sb;
        for (int i = 0; i < 40; i++) begin
            r_op  = 3'($urandom);
            r_amt = 4'($urandom);
            r_din = 8'($urandom);
            r_sb  = 16'($urandom);
            do_cmd(r_op, r_amt, r_din, r_sb, 1'($urandom), 1'($urandom), "rand");
        end
        // Leave a clean idle cycle so the last command's done pulse is checked low.
        @(posedge clock); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || Q !== m_q) begin
            n_err++;
            $display("FAIL rand_tail: done=%b busy=%b Q=%h, want 0 0 %h", done, busy, Q, m_q);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load_ror();
        test_sra_srl();
        test_large_amount();
        test_serial();
        test_zero_and_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
